corelet_sequencer: RTL and testbench

//  FSM sequencing one corelet through a convolution: per kernel position (kij) it loads weights, streams activations,

---
 rtl/corelet_pkg.sv | 33 +++
 rtl/corelet_sequencer_if.sv | 34 +++
 rtl/corelet_sequencer_drain_pipe.sv | 34 +++
 rtl/corelet_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_corelet_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet sequencer: FSM state encoding,
// bit positions of the corelet instruction bus, and default sizes.
package corelet_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WFILL,
        S_WKERN,
        S_AFILL,
        S_EXEC,
        S_DRAIN,
        S_NEXT,
        S_FIN
    } state_t;

    // Instruction bus layout: {l0_rd, l0_wr, mode, exec, weightload}
    localparam int INST_L0_RD = 4;
    localparam int INST_L0_WR = 3;
    localparam int INST_MODE  = 2;
    localparam int INST_EXEC  = 1;
    localparam int INST_WLOAD = 0;

    localparam int DEF_ROW     = 8;
    localparam int DEF_COL     = 8;
    localparam int DEF_KIJ_W   = 4;
    localparam int DEF_ACT_W   = 8;
    localparam int DEF_XADDR_W = 11;
    localparam int DEF_PADDR_W = 8;
    localparam int DEF_W_BASE  = 0;
    localparam int DEF_A_BASE  = 1024;
    localparam int DEF_WB_LAT  = 3;

endpackage

// File: rtl/corelet_sequencer_if.sv
// Bus between the sequencer and the corelet / memories: instruction word,
// xmem read port, OFIFO handshake, SFU controls and ping-pong psum ports.
interface corelet_sequencer_if
    import corelet_pkg::*;
#(
    parameter int XADDR_W = DEF_XADDR_W,
    parameter int PADDR_W = DEF_PADDR_W
);
    logic [4:0]         inst;
    logic               xmem_cen;
    logic [XADDR_W-1:0] xmem_addr;
    logic               ofifo_valid;
    logic               ofifo_rd;
    logic               sfu_en;
    logic               relu;
    logic               pmem_ren;
    logic [PADDR_W-1:0] pmem_raddr;
    logic               pmem_rbank;
    logic               pmem_wen;
    logic [PADDR_W-1:0] pmem_waddr;
    logic               pmem_wbank;

    modport master (
        output inst, xmem_cen, xmem_addr, ofifo_rd, sfu_en, relu,
               pmem_ren, pmem_raddr, pmem_rbank, pmem_wen, pmem_waddr, pmem_wbank,
        input  ofifo_valid
    );

    modport slave (
        input  inst, xmem_cen, xmem_addr, ofifo_rd, sfu_en, relu,
               pmem_ren, pmem_raddr, pmem_rbank, pmem_wen, pmem_waddr, pmem_wbank,
        output ofifo_valid
    );
endinterface

// File: rtl/corelet_sequencer_drain_pipe.sv
// Delay line matching the SFU write-back latency: each OFIFO pop enters
// with its row address and emerges DEPTH cycles later as a psum write.
module drain_pipe #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);
    logic [DEPTH-1:0]  vld;
    logic [ADDR_W-1:0] adr [DEPTH];

    // Shift {valid,addr} one stage per cycle; idle stages carry a zero address
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_valid ? in_addr : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = adr[DEPTH-1];
endmodule

// File: rtl/corelet_sequencer.sv
// Sequences one corelet through a convolution, one kernel position (kij)
// at a time: weight fill, weight load, activation fill, execute, drain to
// ping-pong psum memory. Optional busy-cycle counter under CTRL_PERF_EN.
module corelet_sequencer
    import corelet_pkg::*;
#(
    parameter int ROW     = DEF_ROW,
    parameter int COL     = DEF_COL,
    parameter int KIJ_W   = DEF_KIJ_W,
    parameter int ACT_W   = DEF_ACT_W,
    parameter int XADDR_W = DEF_XADDR_W,
    parameter int PADDR_W = DEF_PADDR_W,
    parameter int W_BASE  = DEF_W_BASE,
    parameter int A_BASE  = DEF_A_BASE,
    parameter int WB_LAT  = DEF_WB_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KIJ_W-1:0] num_kij,
    input  logic [ACT_W-1:0] num_act,
    input  logic             relu_en,
    corelet_sequencer_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [31:0]      perf_cycles
);
    localparam int CNT_W = ((ACT_W + 1) > ($clog2(ROW + COL) + 1)) ? (ACT_W + 1)
                                                                    : ($clog2(ROW + COL) + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [KIJ_W-1:0]   kij;
    logic               bank;
    logic [KIJ_W-1:0]   num_kij_q;
    logic [ACT_W-1:0]   num_act_q;
    logic               relu_q;
    logic               cen_q;
    logic [ACT_W-1:0]   issued;
    logic [ACT_W-1:0]   written;
    logic               ren_q;
    logic [PADDR_W-1:0] raddr_q;
    logic               rbank_q;
    logic               wr_valid;
    logic [PADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]   num_act_ext;

    logic               xmem_cen_c;
    logic [XADDR_W-1:0] xmem_addr_c;
    logic               l0_rd_c, exec_c, wload_c;
    logic               ofifo_rd_c, sfu_en_c, relu_c;
    logic               busy_c, done_c;
    logic [4:0]         inst_c;

    assign num_act_ext = CNT_W'(num_act_q);

    // Next-state and per-state outputs; everything defaults to inactive
    always_comb begin
        state_n     = state;
        xmem_cen_c  = 1'b0;
        xmem_addr_c = '0;
        l0_rd_c     = 1'b0;
        exec_c      = 1'b0;
        wload_c     = 1'b0;
        ofifo_rd_c  = 1'b0;
        sfu_en_c    = 1'b0;
        relu_c      = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (num_kij == '0 || num_act == '0) ? S_FIN : S_WFILL;
                end
            end
            S_WFILL: begin
                busy_c      = 1'b1;
                xmem_cen_c  = 1'b1;
                xmem_addr_c = XADDR_W'(W_BASE) + XADDR_W'(kij) * XADDR_W'(COL) + XADDR_W'(cnt);
                if (cnt == CNT_W'(COL - 1)) state_n = S_WKERN;
            end
            S_WKERN: begin
                busy_c  = 1'b1;
                wload_c = 1'b1;
                l0_rd_c = (cnt < CNT_W'(COL));
                if (cnt == CNT_W'(COL + ROW - 1)) state_n = S_AFILL;
            end
            S_AFILL: begin
                busy_c = 1'b1;
                if (cnt < num_act_ext) begin
                    xmem_cen_c  = 1'b1;
                    xmem_addr_c = XADDR_W'(A_BASE) + XADDR_W'(cnt);
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                busy_c  = 1'b1;
                l0_rd_c = 1'b1;
                exec_c  = 1'b1;
                if (cnt == num_act_ext - CNT_W'(1)) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                busy_c     = 1'b1;
                sfu_en_c   = (kij != '0);
                relu_c     = relu_q && (kij == num_kij_q - KIJ_W'(1));
                ofifo_rd_c = bus.ofifo_valid && (issued < num_act_q);
                if (wr_valid && written == num_act_q - ACT_W'(1)) state_n = S_NEXT;
            end
            S_NEXT: begin
                busy_c  = 1'b1;
                state_n = ((KIJ_W+1)'(kij) + (KIJ_W+1)'(1) < (KIJ_W+1)'(num_kij_q)) ? S_WFILL
                                                                                    : S_FIN;
            end
            S_FIN: begin
                done_c  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, phase counters, run parameters and psum read strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            kij       <= '0;
            bank      <= 1'b0;
            num_kij_q <= '0;
            num_act_q <= '0;
            relu_q    <= 1'b0;
            cen_q     <= 1'b0;
            issued    <= '0;
            written   <= '0;
            ren_q     <= 1'b0;
            raddr_q   <= '0;
            rbank_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + CNT_W'(1);
            if (state == S_IDLE && start) begin
                num_kij_q <= num_kij;
                num_act_q <= num_act;
                relu_q    <= relu_en;
                kij       <= '0;
                bank      <= 1'b0;
            end
            if (state == S_NEXT && state_n == S_WFILL) kij <= kij + KIJ_W'(1);
            if (state == S_DRAIN && state_n == S_NEXT) bank <= ~bank;
            cen_q <= xmem_cen_c;
            if (state != S_DRAIN) begin
                issued  <= '0;
                written <= '0;
            end else begin
                if (ofifo_rd_c) issued <= issued + ACT_W'(1);
                if (wr_valid) written <= written + ACT_W'(1);
            end
            ren_q   <= ofifo_rd_c && (kij != '0);
            raddr_q <= (ofifo_rd_c && kij != '0) ? PADDR_W'(issued) : '0;
            rbank_q <= (ofifo_rd_c && kij != '0) ? bank : 1'b0;
        end
    end

    drain_pipe #(
        .DEPTH  (WB_LAT),
        .ADDR_W (PADDR_W)
    ) u_drain_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (ofifo_rd_c),
        .in_addr   (PADDR_W'(issued)),
        .out_valid (wr_valid),
        .out_addr  (wr_addr)
    );

    // Pack the instruction word; mode stays 0 for this dataflow
    always_comb begin
        inst_c             = '0;
        inst_c[INST_L0_RD] = l0_rd_c;
        inst_c[INST_L0_WR] = cen_q;
        inst_c[INST_MODE]  = 1'b0;
        inst_c[INST_EXEC]  = exec_c;
        inst_c[INST_WLOAD] = wload_c;
    end

    assign bus.inst       = inst_c;
    assign bus.xmem_cen   = xmem_cen_c;
    assign bus.xmem_addr  = xmem_addr_c;
    assign bus.ofifo_rd   = ofifo_rd_c;
    assign bus.sfu_en     = sfu_en_c;
    assign bus.relu       = relu_c;
    assign bus.pmem_ren   = ren_q;
    assign bus.pmem_raddr = raddr_q;
    assign bus.pmem_rbank = rbank_q;
    assign bus.pmem_wen   = wr_valid;
    assign bus.pmem_waddr = wr_addr;
    assign bus.pmem_wbank = wr_valid ? ~bank : 1'b0;
    assign busy           = busy_c;
    assign done           = done_c;

`ifdef CTRL_PERF_EN
    logic [31:0] perf_q;

    // Count busy cycles; restart on an accepted start and hold after done
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state == S_IDLE && start) begin
            perf_q <= '0;
        end else if (busy_c) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_corelet_sequencer.sv
// Directed bench for corelet_sequencer: full runs, multi-kij bank
// ping-pong, OFIFO stall, zero-size runs and reset in the middle of a run.
module tb_corelet_sequencer;
    import corelet_pkg::*;

`ifdef CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  num_kij;
    logic [7:0]  num_act;
    logic        relu_en;
    logic        busy;
    logic        done;
    logic [31:0] perf_cycles;

    corelet_sequencer_if bus ();

    corelet_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_kij     (num_kij),
        .num_act     (num_act),
        .relu_en     (relu_en),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    int xaddr_q[$];
    int wr_addr_q[$], wr_bank_q[$], wr_sfu_q[$], wr_relu_q[$];
    int rd_addr_q[$], rd_bank_q[$];
    int l0wr_cnt, l0rd_cnt, wload_cnt, exec_cnt, mode_cnt, ofrd_cnt, busy_cnt, done_cnt;
    int done_at, first_rd_at, first_wr_at, first_l0wr_at;
    logic [31:0] perf_at_done, perf_final;

    task automatic sample(input int c);
        if (bus.xmem_cen) xaddr_q.push_back(int'(bus.xmem_addr));
        if (bus.inst[INST_L0_WR]) begin
            l0wr_cnt++;
            if (first_l0wr_at < 0) first_l0wr_at = c;
        end
        if (bus.inst[INST_L0_RD]) l0rd_cnt++;
        if (bus.inst[INST_WLOAD]) wload_cnt++;
        if (bus.inst[INST_EXEC]) exec_cnt++;
        if (bus.inst[INST_MODE]) mode_cnt++;
        if (bus.ofifo_rd) begin
            ofrd_cnt++;
            if (first_rd_at < 0) first_rd_at = c;
        end
        if (bus.pmem_wen) begin
            wr_addr_q.push_back(int'(bus.pmem_waddr));
            wr_bank_q.push_back(int'(bus.pmem_wbank));
            wr_sfu_q.push_back(int'(bus.sfu_en));
            wr_relu_q.push_back(int'(bus.relu));
            if (first_wr_at < 0) first_wr_at = c;
        end
        if (bus.pmem_ren) begin
            rd_addr_q.push_back(int'(bus.pmem_raddr));
            rd_bank_q.push_back(int'(bus.pmem_rbank));
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic kick(input logic [3:0] nk, input logic [7:0] na, input logic re);
        @(negedge clk);
        num_kij = nk;
        num_act = na;
        relu_en = re;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Step cycle by cycle from the first cycle after start until done (bounded)
    task automatic capture(input int budget, input int valid_from, input int restart_at);
        xaddr_q.delete(); wr_addr_q.delete(); wr_bank_q.delete(); wr_sfu_q.delete();
        wr_relu_q.delete(); rd_addr_q.delete(); rd_bank_q.delete();
        l0wr_cnt = 0; l0rd_cnt = 0; wload_cnt = 0; exec_cnt = 0; mode_cnt = 0;
        ofrd_cnt = 0; busy_cnt = 0; done_cnt = 0;
        done_at = -1; first_rd_at = -1; first_wr_at = -1; first_l0wr_at = -1;
        perf_at_done = 32'hFFFF_FFFF;
        for (int c = 0; c < budget; c++) begin
            bus.ofifo_valid = (c >= valid_from);
            start = (c == restart_at);
            if (c == restart_at) begin
                num_kij = 4'd1;
                num_act = 8'd1;
            end
            #1;
            sample(c);
            if (done) begin
                done_at      = c;
                perf_at_done = perf_cycles;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            #1;
            sample(budget + t);
        end
        perf_final = perf_cycles;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        num_kij = '0;
        num_act = '0;
        relu_en = 1'b0;
        bus.ofifo_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.inst, bus.xmem_cen, bus.xmem_addr, bus.ofifo_rd, bus.sfu_en, bus.relu,
             bus.pmem_ren, bus.pmem_raddr, bus.pmem_rbank, bus.pmem_wen, bus.pmem_waddr,
             bus.pmem_wbank, busy, done} !== '0) begin
            $display("[TB] FAIL reset_outputs: got nonzero outputs, want all 0");
            n_fail++;
        end
        n_cmp++;
        if (perf_cycles !== 32'd0) begin
            $display("[TB] FAIL reset_perf: got %0d want 0", perf_cycles);
            n_fail++;
        end
        reset = 1'b0;
    endtask

    task automatic test_basic(input string tag);
        int exp_perf;
        exp_perf = PERF ? 41 : 0;
        kick(4'd1, 8'd4, 1'b0);
        capture(200, 0, -1);
        n_cmp++;
        if (done_at !== 41) begin $display("[TB] FAIL %s done_at: got %0d want 41", tag, done_at); n_fail++; end
        n_cmp++;
        if (busy_cnt !== 41) begin $display("[TB] FAIL %s busy_cycles: got %0d want 41", tag, busy_cnt); n_fail++; end
        n_cmp++;
        if (done_cnt !== 1) begin $display("[TB] FAIL %s done_pulses: got %0d want 1", tag, done_cnt); n_fail++; end
        n_cmp++;
        if (xaddr_q.size() !== 12) begin $display("[TB] FAIL %s xmem_reads: got %0d want 12", tag, xaddr_q.size()); n_fail++; end
        for (int i = 0; i < 12 && i < xaddr_q.size(); i++) begin
            int e;
            e = (i < 8) ? i : 1024 + i - 8;
            n_cmp++;
            if (xaddr_q[i] !== e) begin $display("[TB] FAIL %s xmem_addr[%0d]: got %0d want %0d", tag, i, xaddr_q[i], e); n_fail++; end
        end
        n_cmp++;
        if (l0wr_cnt !== 12) begin $display("[TB] FAIL %s l0_wr_count: got %0d want 12", tag, l0wr_cnt); n_fail++; end
        n_cmp++;
        if (first_l0wr_at !== 1) begin $display("[TB] FAIL %s first_l0_wr: got %0d want 1", tag, first_l0wr_at); n_fail++; end
        n_cmp++;
        if (wload_cnt !== 16) begin $display("[TB] FAIL %s weightload_count: got %0d want 16", tag, wload_cnt); n_fail++; end
        n_cmp++;
        if (l0rd_cnt !== 12) begin $display("[TB] FAIL %s l0_rd_count: got %0d want 12", tag, l0rd_cnt); n_fail++; end
        n_cmp++;
        if (exec_cnt !== 4) begin $display("[TB] FAIL %s exec_count: got %0d want 4", tag, exec_cnt); n_fail++; end
        n_cmp++;
        if (mode_cnt !== 0) begin $display("[TB] FAIL %s mode_count: got %0d want 0", tag, mode_cnt); n_fail++; end
        n_cmp++;
        if (rd_addr_q.size() !== 0) begin $display("[TB] FAIL %s pmem_reads: got %0d want 0", tag, rd_addr_q.size()); n_fail++; end
        n_cmp++;
        if (ofrd_cnt !== 4) begin $display("[TB] FAIL %s ofifo_rd_count: got %0d want 4", tag, ofrd_cnt); n_fail++; end
        n_cmp++;
        if (first_rd_at !== 33) begin $display("[TB] FAIL %s first_ofifo_rd: got %0d want 33", tag, first_rd_at); n_fail++; end
        n_cmp++;
        if (first_wr_at !== 36) begin $display("[TB] FAIL %s first_pmem_wen: got %0d want 36", tag, first_wr_at); n_fail++; end
        n_cmp++;
        if (wr_addr_q.size() !== 4) begin $display("[TB] FAIL %s pmem_writes: got %0d want 4", tag, wr_addr_q.size()); n_fail++; end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if ({wr_addr_q[i], wr_bank_q[i], wr_sfu_q[i], wr_relu_q[i]} !== {i, 1, 0, 0}) begin
                $display("[TB] FAIL %s pmem_write[%0d]: got addr %0d bank %0d sfu %0d relu %0d want addr %0d bank 1 sfu 0 relu 0",
                         tag, i, wr_addr_q[i], wr_bank_q[i], wr_sfu_q[i], wr_relu_q[i], i);
                n_fail++;
            end
        end
        n_cmp++;
        if (perf_at_done !== 32'(exp_perf)) begin $display("[TB] FAIL %s perf_at_done: got %0d want %0d", tag, perf_at_done, exp_perf); n_fail++; end
        n_cmp++;
        if (perf_final !== 32'(exp_perf)) begin $display("[TB] FAIL %s perf_held: got %0d want %0d", tag, perf_final, exp_perf); n_fail++; end
    endtask

    task automatic test_multi_kij();
        int exp_wa[6] = '{0, 1, 0, 1, 0, 1};
        int exp_wb[6] = '{1, 1, 0, 0, 1, 1};
        int exp_sf[6] = '{0, 0, 1, 1, 1, 1};
        int exp_rl[6] = '{0, 0, 0, 0, 1, 1};
        int exp_ra[4] = '{0, 1, 0, 1};
        int exp_rb[4] = '{1, 1, 0, 0};
        kick(4'd3, 8'd2, 1'b1);
        capture(400, 0, 10);
        n_cmp++;
        if (done_at !== 105) begin $display("[TB] FAIL multi done_at: got %0d want 105", done_at); n_fail++; end
        n_cmp++;
        if (done_cnt !== 1) begin $display("[TB] FAIL multi done_pulses: got %0d want 1", done_cnt); n_fail++; end
        n_cmp++;
        if (busy_cnt !== 105) begin $display("[TB] FAIL multi busy_cycles: got %0d want 105", busy_cnt); n_fail++; end
        n_cmp++;
        if (xaddr_q.size() !== 30) begin $display("[TB] FAIL multi xmem_reads: got %0d want 30", xaddr_q.size()); n_fail++; end
        for (int i = 0; i < 30 && i < xaddr_q.size(); i++) begin
            int k, j, e;
            k = i / 10;
            j = i % 10;
            e = (j < 8) ? 8 * k + j : 1024 + j - 8;
            n_cmp++;
            if (xaddr_q[i] !== e) begin $display("[TB] FAIL multi xmem_addr[%0d]: got %0d want %0d", i, xaddr_q[i], e); n_fail++; end
        end
        n_cmp++;
        if (wr_addr_q.size() !== 6) begin $display("[TB] FAIL multi pmem_writes: got %0d want 6", wr_addr_q.size()); n_fail++; end
        for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if ({wr_addr_q[i], wr_bank_q[i], wr_sfu_q[i], wr_relu_q[i]} !== {exp_wa[i], exp_wb[i], exp_sf[i], exp_rl[i]}) begin
                $display("[TB] FAIL multi pmem_write[%0d]: got addr %0d bank %0d sfu %0d relu %0d want addr %0d bank %0d sfu %0d relu %0d",
                         i, wr_addr_q[i], wr_bank_q[i], wr_sfu_q[i], wr_relu_q[i], exp_wa[i], exp_wb[i], exp_sf[i], exp_rl[i]);
                n_fail++;
            end
        end
        n_cmp++;
        if (rd_addr_q.size() !== 4) begin $display("[TB] FAIL multi pmem_reads: got %0d want 4", rd_addr_q.size()); n_fail++; end
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
            n_cmp++;
            if ({rd_addr_q[i], rd_bank_q[i]} !== {exp_ra[i], exp_rb[i]}) begin
                $display("[TB] FAIL multi pmem_read[%0d]: got addr %0d bank %0d want addr %0d bank %0d",
                         i, rd_addr_q[i], rd_bank_q[i], exp_ra[i], exp_rb[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_stall();
        kick(4'd1, 8'd4, 1'b0);
        capture(200, 43, -1);
        n_cmp++;
        if (first_rd_at !== 43) begin $display("[TB] FAIL stall first_ofifo_rd: got %0d want 43", first_rd_at); n_fail++; end
        n_cmp++;
        if (first_wr_at !== 46) begin $display("[TB] FAIL stall first_pmem_wen: got %0d want 46", first_wr_at); n_fail++; end
        n_cmp++;
        if (done_at !== 51) begin $display("[TB] FAIL stall done_at: got %0d want 51", done_at); n_fail++; end
        n_cmp++;
        if (ofrd_cnt !== 4) begin $display("[TB] FAIL stall ofifo_rd_count: got %0d want 4", ofrd_cnt); n_fail++; end
        n_cmp++;
        if (wr_addr_q.size() !== 4) begin $display("[TB] FAIL stall pmem_writes: got %0d want 4", wr_addr_q.size()); n_fail++; end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if ({wr_addr_q[i], wr_bank_q[i]} !== {i, 1}) begin
                $display("[TB] FAIL stall pmem_write[%0d]: got addr %0d bank %0d want addr %0d bank 1", i, wr_addr_q[i], wr_bank_q[i], i);
                n_fail++;
            end
        end
    endtask

    task automatic test_zero_size();
        logic [3:0] nk_v[2] = '{4'd1, 4'd0};
        logic [7:0] na_v[2] = '{8'd0, 8'd5};
        for (int v = 0; v < 2; v++) begin
            kick(nk_v[v], na_v[v], 1'b0);
            capture(20, 0, -1);
            n_cmp++;
            if (done_at !== 0) begin $display("[TB] FAIL zero%0d done_at: got %0d want 0", v, done_at); n_fail++; end
            n_cmp++;
            if (done_cnt !== 1) begin $display("[TB] FAIL zero%0d done_pulses: got %0d want 1", v, done_cnt); n_fail++; end
            n_cmp++;
            if (busy_cnt !== 0) begin $display("[TB] FAIL zero%0d busy_cycles: got %0d want 0", v, busy_cnt); n_fail++; end
            n_cmp++;
            if (xaddr_q.size() + wr_addr_q.size() + l0wr_cnt !== 0) begin
                $display("[TB] FAIL zero%0d mem_traffic: got %0d events want 0", v, xaddr_q.size() + wr_addr_q.size() + l0wr_cnt);
                n_fail++;
            end
            n_cmp++;
            if (perf_at_done !== 32'd0) begin $display("[TB] FAIL zero%0d perf: got %0d want 0", v, perf_at_done); n_fail++; end
        end
    endtask

    task automatic test_reset_mid_run();
        int dcnt;
        kick(4'd1, 8'd4, 1'b0);
        bus.ofifo_valid = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.inst, bus.xmem_cen, bus.xmem_addr, bus.ofifo_rd, bus.sfu_en, bus.relu,
             bus.pmem_ren, bus.pmem_raddr, bus.pmem_rbank, bus.pmem_wen, bus.pmem_waddr,
             bus.pmem_wbank, busy, done} !== '0) begin
            $display("[TB] FAIL midreset_outputs: got nonzero outputs, want all 0");
            n_fail++;
        end
        reset = 1'b0;
        dcnt = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        n_cmp++;
        if (dcnt !== 0) begin $display("[TB] FAIL midreset_idle: got %0d busy/done cycles want 0", dcnt); n_fail++; end
        test_basic("after_reset");
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic("basic");
        test_multi_kij();
        test_stall();
        test_zero_size();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop if the scenario sequence itself stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion want summary before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
